// File: rtl/zone_buf_scheduler.sv
// Double-buffered backlight zone store: the writer fills the hidden bank while the LED
// driver streams the displayed bank, optionally scaled by ambient brightness.
module zone_buf_scheduler #(
  parameter int ZONES = 360,
  parameter int DW    = 8,
  parameter int AW    = 9
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  input  logic          I_wr_en,
  input  logic [AW-1:0] I_wr_addr,
  input  logic [DW-1:0] I_wr_data,
  input  logic          I_wr_last,
  input  logic          I_rd_start,
  input  logic          I_rd_ready,
  input  logic [7:0]    I_bright,
  input  logic          I_bright_en,
  output logic          O_rd_valid,
  output logic [AW-1:0] O_rd_addr,
  output logic [DW-1:0] O_rd_data,
  output logic          O_rd_last,
  output logic          O_busy,
  output logic          O_rd_bank,
  output logic [7:0]    O_drop_cnt
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem0 [ZONES];
  logic [DW-1:0] mem1 [ZONES];
  logic [DW-1:0] rd_word;
  logic          rd_bank, pending, bank_valid, fetch_ph, scale_en;
  logic [7:0]    bright_q;
  logic [AW-1:0] addr;
  logic          accept, swap, wr_ok, at_last;
  logic [DW+8:0] prod;
  logic [DW-1:0] scaled;

  assign accept  = (state == IDLE) && I_rd_start;
  // A frame completing in the same cycle as the start is still shown in this pass
  assign swap    = accept && (pending || I_wr_last);
  assign wr_ok   = I_wr_en && ({1'b0, I_wr_addr} < (AW+1)'(ZONES));
  assign at_last = (addr == AW'(ZONES - 1));
  assign prod    = (DW+9)'(rd_word) * (DW+9)'({1'b0, bright_q} + 9'd1);
  assign scaled  = DW'(prod >> 8);
  assign O_busy    = (state != IDLE);
  assign O_rd_bank = rd_bank;

  // Writer always targets the hidden bank; read port follows the displayed bank
  always_ff @(posedge I_clk) begin
    if (wr_ok) begin
      if (rd_bank) mem0[I_wr_addr] <= I_wr_data;
      else         mem1[I_wr_addr] <= I_wr_data;
    end
    rd_word <= rd_bank ? mem1[addr] : mem0[addr];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (I_rd_start) state_nxt = FETCH;
      FETCH:   if (fetch_ph)   state_nxt = SEND;
      SEND:    if (I_rd_ready) state_nxt = O_rd_last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rd_bank    <= 1'b0;
      pending    <= 1'b0;
      bank_valid <= 1'b0;
      fetch_ph   <= 1'b0;
      scale_en   <= 1'b0;
      bright_q   <= '0;
      addr       <= '0;
      O_rd_valid <= 1'b0;
      O_rd_addr  <= '0;
      O_rd_data  <= '0;
      O_rd_last  <= 1'b0;
      O_drop_cnt <= '0;
    end else begin
      if (accept) begin
        addr     <= '0;
        fetch_ph <= 1'b0;
        bright_q <= I_bright;
        scale_en <= I_bright_en;
      end
      if (swap) begin
        rd_bank    <= ~rd_bank;
        bank_valid <= 1'b1;
      end
      if (swap)           pending <= 1'b0;
      else if (I_wr_last) pending <= 1'b1;
      if (I_wr_last && pending && (O_drop_cnt != 8'hFF))
        O_drop_cnt <= O_drop_cnt + 8'd1;
      // First FETCH cycle waits for rd_word to reflect addr; second registers the word
      if (state == FETCH) begin
        fetch_ph <= ~fetch_ph;
        if (fetch_ph) begin
          O_rd_valid <= 1'b1;
          O_rd_addr  <= addr;
          O_rd_data  <= !bank_valid ? '0 : (scale_en ? scaled : rd_word);
          O_rd_last  <= at_last;
        end
      end
      if ((state == SEND) && I_rd_ready) begin
        O_rd_valid <= 1'b0;
        O_rd_last  <= 1'b0;
        addr       <= addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_zone_buf_scheduler.sv
// Directed bench for zone_buf_scheduler: bank swaps, scaling, back-pressure, frame drops
// and reset behaviour, each scenario checked against hand-derived expectations.
module tb_zone_buf_scheduler;
  localparam int ZONES = 360;
  localparam int DW    = 8;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, wr_last, rd_start, rd_ready, bright_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    bright;
  logic          rd_valid, rd_last, busy, rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_mem [ZONES];
  logic [7:0] obs     [ZONES];

  always #5 clk = ~clk;

  zone_buf_scheduler #(.ZONES(ZONES), .DW(DW), .AW(AW)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_wr_en(wr_en), .I_wr_addr(wr_addr),
    .I_wr_data(wr_data), .I_wr_last(wr_last), .I_rd_start(rd_start),
    .I_rd_ready(rd_ready), .I_bright(bright), .I_bright_en(bright_en),
    .O_rd_valid(rd_valid), .O_rd_addr(rd_addr), .O_rd_data(rd_data),
    .O_rd_last(rd_last), .O_busy(busy), .O_rd_bank(rd_bank), .O_drop_cnt(drop_cnt)
  );

  task automatic write_frame(input int ofs);
    for (int i = 0; i < ZONES; i++) begin
      @(negedge clk); wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'((i + ofs) & 255);
    end
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic pulse_last();
    @(negedge clk); wr_last = 1'b1;
    @(negedge clk); wr_last = 1'b0;
  endtask

  task automatic set_exp(input int ofs, input bit en, input int b);
    for (int i = 0; i < ZONES; i++) begin
      int d;
      d = (i + ofs) & 255;
      exp_mem[i] = en ? 8'((d * (b + 1)) >> 8) : 8'(d);
    end
  endtask

  // Cycle numbering: the cycle in which start is sampled is cycle 0
  task automatic run_pass(input string tag, input int low_pct, input bit with_last,
                          input bit en, input logic [7:0] b, input logic exp_bank);
    int idx = 0, cyc, first = -1;
    bit rdy;
    logic pv = 1'b0, pl = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [7:0] pd = '0;
    @(negedge clk); rd_start = 1'b1; bright_en = en; bright = b; wr_last = with_last;
    @(negedge clk); rd_start = 1'b0; wr_last = 1'b0;
    cyc = 1;
    while (idx < ZONES && cyc < 6000) begin
      rdy = ($urandom_range(99) >= low_pct); rd_ready = rdy;
      @(posedge clk); #1; cyc++;
      if (pv && rdy) begin
        total++;
        if (pa !== AW'(idx) || pd !== exp_mem[idx] || pl !== (idx == ZONES - 1)) begin
          bad++;
          $display("FAIL %s word %0d: addr=%0d data=%0d last=%b, want addr=%0d data=%0d last=%b",
                   tag, idx, pa, pd, pl, idx, exp_mem[idx], (idx == ZONES - 1));
        end
        obs[idx] = pd; idx++;
      end else if (pv) begin
        total++;
        if (rd_valid !== 1'b1 || rd_addr !== pa || rd_data !== pd || rd_last !== pl) begin
          bad++;
          $display("FAIL %s hold: valid=%b addr=%0d data=%0d, want valid=1 addr=%0d data=%0d",
                   tag, rd_valid, rd_addr, rd_data, pa, pd);
        end
      end
      if (rd_valid === 1'b1 && first < 0) first = cyc;
      pv = rd_valid; pa = rd_addr; pd = rd_data; pl = rd_last;
      @(negedge clk);
    end
    total++;
    if (idx != ZONES) begin
      bad++; $display("FAIL %s words: got %0d within budget, want %0d", tag, idx, ZONES);
    end
    total++;
    if (first != 3) begin
      bad++; $display("FAIL %s latency: first valid in cycle %0d, want 3", tag, first);
    end
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s end: valid=%b busy=%b, want 0 0", tag, rd_valid, busy);
    end
    total++;
    if (rd_bank !== exp_bank) begin
      bad++; $display("FAIL %s bank: got %b want %b", tag, rd_bank, exp_bank);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({rd_valid, rd_last, busy, rd_bank} !== 4'b0 || rd_addr !== '0 || rd_data !== '0 || drop_cnt !== '0) begin
      bad++;
      $display("FAIL reset: valid=%b last=%b busy=%b bank=%b addr=%0d data=%0d drop=%0d, want all 0",
               rd_valid, rd_last, busy, rd_bank, rd_addr, rd_data, drop_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    write_frame(0);
    pulse_last();
    set_exp(0, 0, 0);
    run_pass("basic", 0, 0, 0, 8'd0, 1'b1);
  endtask

  task automatic test_scaling();
    set_exp(0, 1, 127);
    run_pass("scale127", 0, 0, 1, 8'd127, 1'b1);
    total++;
    if (obs[200] !== 8'd100 || obs[255] !== 8'd127) begin
      bad++; $display("FAIL scale127 zones: z200=%0d z255=%0d, want 100 127", obs[200], obs[255]);
    end
    set_exp(0, 0, 0);
    run_pass("scale255", 0, 0, 1, 8'd255, 1'b1);
  endtask

  task automatic test_backpressure();
    set_exp(0, 0, 0);
    run_pass("backpressure", 30, 0, 0, 8'd0, 1'b1);
  endtask

  task automatic test_drop();
    write_frame(1); pulse_last();
    write_frame(2); pulse_last();
    write_frame(3); pulse_last();
    total++;
    if (drop_cnt !== 8'd2) begin
      bad++; $display("FAIL drop3: got %0d want 2", drop_cnt);
    end
    set_exp(3, 0, 0);
    run_pass("drop_frame", 0, 0, 0, 8'd0, 1'b0);
    for (int i = 0; i < 300; i++) pulse_last();
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++; $display("FAIL drop_sat: got %0d want 255", drop_cnt);
    end
  endtask

  task automatic test_reset_midpass();
    int cyc = 0;
    bit seen = 1'b0;
    @(negedge clk); rd_start = 1'b1; rd_ready = 1'b1; bright_en = 1'b0;
    @(negedge clk); rd_start = 1'b0;
    while (!(rd_valid === 1'b1 && rd_addr === AW'(100)) && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
    end
    total++;
    if (cyc >= 2000 || rd_bank !== 1'b1 || rd_data !== 8'd100) begin
      bad++; $display("FAIL midpass word100: cycles=%0d bank=%b data=%0d, want bank=1 data=100",
                      cyc, rd_bank, rd_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rd_valid, rd_last, busy, rd_bank} !== 4'b0 || rd_addr !== '0 || rd_data !== '0 || drop_cnt !== '0) begin
      bad++;
      $display("FAIL midpass reset: valid=%b last=%b busy=%b bank=%b addr=%0d data=%0d drop=%0d, want all 0",
               rd_valid, rd_last, busy, rd_bank, rd_addr, rd_data, drop_cnt);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rd_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL midpass idle: valid/busy seen high after release, want 0");
    end
  endtask

  task automatic test_first_and_coincide();
    for (int i = 0; i < ZONES; i++) exp_mem[i] = 8'd0;
    run_pass("no_frame", 0, 0, 0, 8'd0, 1'b0);
    write_frame(7);
    @(negedge clk); wr_en = 1'b1; wr_addr = AW'(400); wr_data = 8'hEE;
    @(negedge clk); wr_en = 1'b0;
    set_exp(7, 0, 0);
    run_pass("coincide", 0, 1, 0, 8'd0, 1'b1);
    total++;
    if (obs[40] !== 8'd47 || obs[144] !== 8'd151) begin
      bad++; $display("FAIL addr400: z40=%0d z144=%0d, want 47 151", obs[40], obs[144]);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_last = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    bright_en = 1'b0; bright = '0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_basic();
    test_scaling();
    test_backpressure();
    test_drop();
    test_reset_midpass();
    test_first_and_coincide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
